pipe_hazard_ctrl: RTL

Central hazard and sequencing controller for the 5-stage pipeline. It drives the `en` and `rst` (flush) inputs of the PC, IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers. It resolves load-use stalls, branch-mispredict flushes and data-memory wait states with a fixed priority. It also keeps stall and flush performance counters and a memory-timeout flag.

---
 rtl/pipe_hazard_ctrl.sv | 212 +++++++++++++++++++++
 1 files changed

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: central hazard/sequencing controller for the 5-stage pipeline.
// Resolves data-memory wait states, branch-mispredict flushes and load-use
// stalls with fixed priority, and drives the enable/flush pins of every
// pipeline register.
//
// Ports:
//   clk, rst                    clock, synchronous active-high reset
//   id_rs1_addr, id_rs2_addr    source registers of the instruction in ID
//   id_uses_rs1, id_uses_rs2    ID instruction actually reads rs1 / rs2
//   ex_memread, ex_rd           load flag and destination of the instruction in EX
//   ex_mispredict               branch resolved in EX disagrees with prediction
//   mem_req, mem_ready          MEM-stage access pending / completing this cycle
//   pc_en .. mem_wb_en          pipeline register enables (combinational)
//   if_id_flush .. ex_mem_flush pipeline register flushes (combinational)
//   stall_cycles, flush_count   performance counters (wrap mod 2^32)
//   mem_timeout                 sticky flag: a memory access waited too long
//   state                       debug view: 0=RUN, 1=LU_STALL, 2=MEM_WAIT
module pipe_hazard_ctrl #(
    parameter int unsigned LOAD_STALL  = 1,
    parameter int unsigned MEM_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  id_rs1_addr,
    input  logic [4:0]  id_rs2_addr,
    input  logic        id_uses_rs1,
    input  logic        id_uses_rs2,
    input  logic        ex_memread,
    input  logic [4:0]  ex_rd,
    input  logic        ex_mispredict,
    input  logic        mem_req,
    input  logic        mem_ready,
    output logic        pc_en,
    output logic        if_id_en,
    output logic        id_ex_en,
    output logic        ex_mem_en,
    output logic        mem_wb_en,
    output logic        if_id_flush,
    output logic        id_ex_flush,
    output logic        ex_mem_flush,
    output logic [31:0] stall_cycles,
    output logic [31:0] flush_count,
    output logic        mem_timeout,
    output logic [1:0]  state
);

    localparam int unsigned CNT_W  = 32;
    localparam int unsigned WAIT_W = 16;
    localparam int unsigned LU_W   = 4;

    localparam logic [WAIT_W-1:0] WAIT_MAX  = {WAIT_W{1'b1}};
    localparam logic [WAIT_W-1:0] TIMEOUT_V = WAIT_W'(MEM_TIMEOUT);
    localparam logic [LU_W-1:0]   LU_INIT   = LU_W'(LOAD_STALL - 1);

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_LU_STALL = 2'd1,
        ST_MEM_WAIT = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        ACT_NORMAL,
        ACT_FLUSH,
        ACT_BUBBLE,
        ACT_FREEZE
    } act_t;

    state_t              cur_state, nxt_state;
    act_t                act;
    logic [LU_W-1:0]     lu_cnt, lu_cnt_nxt;
    logic [WAIT_W-1:0]   wait_cnt, wait_cnt_nxt;
    logic                timeout_set;
    logic                mem_stall;
    logic                load_use;

    assign state = cur_state;

    // Hazard detection and fixed-priority action select.
    // In MEM_WAIT a dropped mem_req counts as release, which mem_stall covers.
    always_comb begin
        mem_stall = mem_req & ~mem_ready;
        load_use  = ex_memread & (ex_rd != 5'd0) &
                    ((id_uses_rs1 & (id_rs1_addr == ex_rd)) |
                     (id_uses_rs2 & (id_rs2_addr == ex_rd)));
        act = ACT_NORMAL;
        if (mem_stall) begin
            act = ACT_FREEZE;
        end else if (ex_mispredict) begin
            act = ACT_FLUSH;
        end else if (load_use || (cur_state == ST_LU_STALL)) begin
            act = ACT_BUBBLE;
        end
    end

    // Next-state, bubble counter and wait counter.
    always_comb begin
        nxt_state    = cur_state;
        lu_cnt_nxt   = lu_cnt;
        wait_cnt_nxt = wait_cnt;
        timeout_set  = 1'b0;
        case (cur_state)
            ST_LU_STALL: begin
                case (act)
                    ACT_FREEZE: ;
                    ACT_FLUSH: begin
                        nxt_state  = ST_RUN;
                        lu_cnt_nxt = '0;
                    end
                    default: begin
                        lu_cnt_nxt = lu_cnt - LU_W'(1);
                        if (lu_cnt == LU_W'(1)) begin
                            nxt_state = ST_RUN;
                        end
                    end
                endcase
            end
            default: begin
                // RUN, and MEM_WAIT once released, share the same rules.
                wait_cnt_nxt = '0;
                nxt_state    = ST_RUN;
                case (act)
                    ACT_FREEZE: begin
                        nxt_state = ST_MEM_WAIT;
                        if (cur_state != ST_MEM_WAIT) begin
                            wait_cnt_nxt = WAIT_W'(1);
                        end else if (wait_cnt == WAIT_MAX) begin
                            wait_cnt_nxt = wait_cnt;
                        end else begin
                            wait_cnt_nxt = wait_cnt + WAIT_W'(1);
                        end
                        timeout_set = (wait_cnt_nxt >= TIMEOUT_V);
                    end
                    ACT_BUBBLE: begin
                        if (LOAD_STALL > 1) begin
                            nxt_state  = ST_LU_STALL;
                            lu_cnt_nxt = LU_INIT;
                        end
                    end
                    default: ;
                endcase
            end
        endcase
    end

    // Mealy output decode; reset forces all registers held and flushed.
    always_comb begin
        pc_en        = 1'b1;
        if_id_en     = 1'b1;
        id_ex_en     = 1'b1;
        ex_mem_en    = 1'b1;
        mem_wb_en    = 1'b1;
        if_id_flush  = 1'b0;
        id_ex_flush  = 1'b0;
        ex_mem_flush = 1'b0;
        if (rst) begin
            pc_en        = 1'b0;
            if_id_en     = 1'b0;
            id_ex_en     = 1'b0;
            ex_mem_en    = 1'b0;
            mem_wb_en    = 1'b0;
            if_id_flush  = 1'b1;
            id_ex_flush  = 1'b1;
            ex_mem_flush = 1'b1;
        end else begin
            case (act)
                ACT_FREEZE: begin
                    pc_en     = 1'b0;
                    if_id_en  = 1'b0;
                    id_ex_en  = 1'b0;
                    ex_mem_en = 1'b0;
                    mem_wb_en = 1'b0;
                end
                ACT_FLUSH: begin
                    if_id_flush = 1'b1;
                    id_ex_flush = 1'b1;
                end
                ACT_BUBBLE: begin
                    pc_en       = 1'b0;
                    if_id_en    = 1'b0;
                    id_ex_flush = 1'b1;
                end
                default: ;
            endcase
        end
    end

    // State, counters and sticky timeout flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            cur_state    <= ST_RUN;
            lu_cnt       <= '0;
            wait_cnt     <= '0;
            stall_cycles <= '0;
            flush_count  <= '0;
            mem_timeout  <= 1'b0;
        end else begin
            cur_state <= nxt_state;
            lu_cnt    <= lu_cnt_nxt;
            wait_cnt  <= wait_cnt_nxt;
            if (!pc_en) begin
                stall_cycles <= stall_cycles + CNT_W'(1);
            end
            if (act == ACT_FLUSH) begin
                flush_count <= flush_count + CNT_W'(1);
            end
            if (timeout_set) begin
                mem_timeout <= 1'b1;
            end
        end
    end

endmodule
